truth_table_scanner: RTL and testbench

Upstream stimulus and capture stage for the small combinational lab functions, such as the 3-input structural/behavioural `f` blocks.
- Walks every input combination in ascending binary order on `x`.
- Holds each combination for a fixed number of clocks, then samples the function output `f`.
- Assembles the results into a truth-table word and compares it against a golden mask.
- Replaces the hand-written `#20` stimulus lists with one reusable synthesizable sequencer.

---
 rtl/truth_table_scanner_pkg.sv | 21 ++
 rtl/truth_table_scanner_lsb_priority_enc.sv | 24 ++
 rtl/truth_table_scanner.sv | 138 +++++++++++++
 tb/tb_truth_table_scanner.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared encodings, default sizing and golden masks for the truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int N_IN_DEF        = 3;
    localparam int HOLD_CYCLES_DEF = 20;
    localparam int CNT_W_DEF       = 8;

    // Golden truth tables for the 3-input lab functions; bit i = f(x==i).
    localparam logic [7:0] MAJ3 = 8'hE8;
    localparam logic [7:0] XOR3 = 8'h96;
    localparam logic [7:0] AND3 = 8'h80;

endpackage

// File: rtl/truth_table_scanner_lsb_priority_enc.sv
// Lowest-set-bit priority encoder with an any-set flag.
// Latency: purely combinational.
// Backpressure: none.
module truth_table_scanner_lsb_priority_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is the last writer and wins.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input vector, samples f at the end of each hold window, grades the table.
// Latency: 2**N_IN*HOLD_CYCLES clocks from accepted start to the done pulse.
// Backpressure: none; start is only accepted in IDLE and is never queued.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [2**N_IN-1:0]   i_expected,
    input  logic                 i_f,
    output logic [N_IN-1:0]      o_x,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_table,
    output logic                 o_pass,
    output logic                 o_mismatch,
    output logic [N_IN-1:0]      o_mismatch_idx
);

    localparam int                TW       = 2**N_IN;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]   X_LAST   = {N_IN{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_IN-1:0]   r_x;
    logic [TW-1:0]     r_exp;
    logic [TW-1:0]     r_table;
    logic              r_pass;
    logic              r_mismatch;
    logic [N_IN-1:0]   r_mis_idx;

    logic              w_accept;
    logic              w_sample;
    logic              w_last;
    logic [TW-1:0]     w_table_nxt;
    logic [N_IN-1:0]   w_idx;
    logic              w_any;

    // State register; reset aborts any scan in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the strobes that steer the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_cnt == CNT_LAST) begin
                    w_sample = 1'b1;
                    if (r_x == X_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Table with the current sample folded in, so grading sees the final bit too.
    always_comb begin
        w_table_nxt      = r_table;
        w_table_nxt[r_x] = i_f;
    end

    truth_table_scanner_lsb_priority_enc #(
        .W     (TW),
        .IDX_W (N_IN)
    ) u_prio (
        .i_vec (w_table_nxt ^ r_exp),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Hold counter, vector walk, table capture and result grading.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_x        <= '0;
            r_exp      <= '0;
            r_table    <= '0;
            r_pass     <= 1'b0;
            r_mismatch <= 1'b0;
            r_mis_idx  <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_exp   <= i_expected;
            r_table <= '0;
        end else if (r_state == ST_SCAN) begin
            if (w_sample) begin
                r_cnt   <= '0;
                r_table <= w_table_nxt;
                if (w_last) begin
                    r_x        <= '0;
                    r_pass     <= ~w_any;
                    r_mismatch <= w_any;
                    r_mis_idx  <= w_idx;
                end else begin
                    r_x <= r_x + N_IN'(1);
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_x            = r_x;
    assign o_busy         = (r_state == ST_SCAN);
    assign o_done         = (r_state == ST_DONE);
    assign o_table        = r_table;
    assign o_pass         = r_pass;
    assign o_mismatch     = r_mismatch;
    assign o_mismatch_idx = r_mis_idx;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (hold 20 and hold 1) against a timing model.
// Latency: n/a.
// Backpressure: n/a.
module tb_truth_table_scanner;
    import truth_table_scanner_pkg::*;

    localparam int H0 = 20;
    localparam int H1 = 1;

    logic       clk;
    logic       rst;
    logic       start  [2];
    logic [7:0] expv   [2];
    logic       f_i    [2];
    logic [2:0] x_o    [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic [7:0] tbl_o  [2];
    logic       pass_o [2];
    logic       mis_o  [2];
    logic [2:0] idx_o  [2];
    int         fsel   [2];
    logic [7:0] rtab   [2];

    int checks = 0;
    int errors = 0;

    function automatic int hk(int k);
        return (k == 0) ? H0 : H1;
    endfunction

    // Function under stimulus: 0 majority, 1 constant 0, 2 xor, 3 and, else table lookup.
    function automatic logic fn(int sel, logic [2:0] x, logic [7:0] rt);
        case (sel)
            0: return (int'(x[2]) + int'(x[1]) + int'(x[0])) >= 2;
            1: return 1'b0;
            2: return ^x;
            3: return &x;
            default: return rt[x];
        endcase
    endfunction

    assign f_i[0] = fn(fsel[0], x_o[0], rtab[0]);
    assign f_i[1] = fn(fsel[1], x_o[1], rtab[1]);

    truth_table_scanner #(.N_IN(3), .HOLD_CYCLES(H0), .CNT_W(8)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_expected(expv[0]), .i_f(f_i[0]),
        .o_x(x_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]), .o_table(tbl_o[0]),
        .o_pass(pass_o[0]), .o_mismatch(mis_o[0]), .o_mismatch_idx(idx_o[0])
    );

    truth_table_scanner #(.N_IN(3), .HOLD_CYCLES(H1), .CNT_W(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_expected(expv[1]), .i_f(f_i[1]),
        .o_x(x_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]), .o_table(tbl_o[1]),
        .o_pass(pass_o[1]), .o_mismatch(mis_o[1]), .o_mismatch_idx(idx_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each scan is defined by its accepting edge c0; everything else is arithmetic on edges since.
    int         ecount = 0;
    bit         act       [2];
    int         c0        [2];
    logic [7:0] pend_tab  [2];
    logic       pend_pass [2];
    logic [2:0] pend_idx  [2];
    logic [7:0] pub_tab   [2];
    logic       pub_pass  [2];
    logic       pub_mis   [2];
    logic [2:0] pub_idx   [2];

    task automatic model_scan(int k);
        logic [7:0] tab;
        bit         found;
        tab   = 8'h00;
        found = 0;
        for (int i = 0; i < 8; i++) tab[i] = fn(fsel[k], 3'(i), rtab[k]);
        pend_tab[k]  = tab;
        pend_pass[k] = (tab == expv[k]);
        pend_idx[k]  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && tab[i] != expv[k][i]) begin
                pend_idx[k] = 3'(i);
                found       = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        ecount = ecount + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act[k]      = 0;
                pub_tab[k]  = 8'h00;
                pub_pass[k] = 1'b0;
                pub_mis[k]  = 1'b0;
                pub_idx[k]  = 3'd0;
            end else begin
                if (act[k] && (ecount - c0[k]) == 8 * hk(k)) begin
                    pub_tab[k]  = pend_tab[k];
                    pub_pass[k] = pend_pass[k];
                    pub_mis[k]  = !pend_pass[k];
                    pub_idx[k]  = pend_idx[k];
                end
                if ((!act[k] || (ecount - 1 - c0[k]) > 8 * hk(k)) && start[k]) begin
                    act[k] = 1;
                    c0[k]  = ecount;
                    model_scan(k);
                end
            end
        end
    end

    function automatic logic [17:0] model_out(int k);
        int         m;
        int         t;
        int         xi;
        logic [7:0] mask;
        if (rst) return 18'h0;
        m = ecount - c0[k];
        t = 8 * hk(k);
        if (act[k] && m < t) begin
            xi   = m / hk(k);
            mask = (8'd1 << xi) - 8'd1;
            return {3'(xi), 1'b1, 1'b0, pend_tab[k] & mask, pub_pass[k], pub_mis[k], pub_idx[k]};
        end
        if (act[k] && m == t)
            return {3'd0, 1'b0, 1'b1, pub_tab[k], pub_pass[k], pub_mis[k], pub_idx[k]};
        return {3'd0, 1'b0, 1'b0, pub_tab[k], pub_pass[k], pub_mis[k], pub_idx[k]};
    endfunction

    task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic start_scan(int k);
        @(posedge clk);
        #2 start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int budget, output int n);
        n = 0;
        while (done_o[k] !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_o[k] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done_k%0d got timeout after %0d want done", k, n);
        end
    endtask

    initial begin
        int n;
        int dcnt;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            expv[k]  = 8'h00;
            fsel[k]  = 1;
            rtab[k]  = 8'h00;
        end

        // Every negedge: both instances against the model.
        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    logic [17:0] got;
                    logic [17:0] want;
                    got  = {x_o[k], busy_o[k], done_o[k], tbl_o[k], pass_o[k], mis_o[k], idx_o[k]};
                    want = model_out(k);
                    checks++;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL model_k%0d got 0x%05h want 0x%05h at %0t", k, got, want, $time);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", {14'd0, x_o[0], busy_o[0], done_o[0], tbl_o[0], pass_o[0], mis_o[0], idx_o[0]}, 32'd0);
        rst = 1'b0;

        // Majority, hold 20.
        fsel[0] = 0; expv[0] = MAJ3;
        start_scan(0);
        wait_done(0, 400, n);
        chk("maj_latency", n, 160);
        chk("maj_table", tbl_o[0], 8'hE8);
        chk("maj_pass", pass_o[0], 1);
        chk("maj_idx", idx_o[0], 0);

        // f stuck at 0.
        fsel[0] = 1;
        start_scan(0);
        wait_done(0, 400, n);
        chk("zero_table", tbl_o[0], 8'h00);
        chk("zero_pass", pass_o[0], 0);
        chk("zero_mismatch", mis_o[0], 1);
        chk("zero_idx", idx_o[0], 3);

        // Reset in the middle of the x==4 hold window.
        fsel[0] = 0;
        start_scan(0);
        n = 0;
        while (x_o[0] !== 3'd4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_x4", x_o[0], 4);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", {14'd0, x_o[0], busy_o[0], done_o[0], tbl_o[0], pass_o[0], mis_o[0], idx_o[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        start_scan(0);
        wait_done(0, 400, n);
        chk("after_reset_pass", pass_o[0], 1);

        // XOR with start re-pulsed during the scan and during done.
        fsel[0] = 2; expv[0] = XOR3;
        start_scan(0);
        dcnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done_o[0] === 1'b1) begin
                dcnt++;
                chk("busy_during_done", busy_o[0], 0);
            end
            start[0] = (i == 5 || i == 100 || done_o[0] === 1'b1);
        end
        start[0] = 1'b0;
        chk("xor_done_pulses", dcnt, 1);
        chk("xor_pass", pass_o[0], 1);

        // AND with a one-clock hold.
        fsel[1] = 3; expv[1] = AND3;
        start_scan(1);
        wait_done(1, 50, n);
        chk("and_latency", n, 8);
        chk("and_table", tbl_o[1], 8'h80);
        chk("and_pass", pass_o[1], 1);

        // Failing scan followed by a passing one.
        fsel[0] = 1; expv[0] = MAJ3;
        start_scan(0);
        wait_done(0, 400, n);
        chk("b2b_first_pass", pass_o[0], 0);
        fsel[0] = 0;
        start_scan(0);
        repeat (80) @(posedge clk);
        #1 chk("b2b_mid_pass", pass_o[0], 0);
        wait_done(0, 400, n);
        chk("b2b_second_pass", pass_o[0], 1);
        chk("b2b_second_mis", mis_o[0], 0);

        // Random tables and expectations; start sometimes held for several clocks.
        for (int it = 0; it < 40; it++) begin
            int k;
            k = (it % 10 == 0) ? 0 : 1;
            fsel[k] = 4;
            rtab[k] = 8'($urandom);
            expv[k] = ($urandom_range(0, 1) == 1) ? rtab[k] : (rtab[k] ^ (8'd1 << $urandom_range(0, 7)));
            @(posedge clk);
            #2 start[k] = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 start[k] = 1'b0;
            wait_done(k, 400, n);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
